// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel processing pipeline.
// Holds the pixel width, the frame-writer state encoding, the pixel-operation
// select codes used by the processing stage, and a lane-index width helper.
package pixel_pkg;

   localparam int unsigned PIX_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      FLUSH = 2'b10,
      DONE  = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      OP_BRIGHTEN  = 2'b00,
      OP_DARKEN    = 2'b01,
      OP_THRESHOLD = 2'b10,
      OP_INVERT    = 2'b11
   } pix_op_e;

   // A single-lane packer still needs a 1-bit index to keep port widths legal.
   function automatic int unsigned lane_width(input int unsigned pack);
      return (pack > 1) ? $clog2(pack) : 1;
   endfunction

endpackage

// File: rtl/pixel_packer.sv
// Lane register file for the frame writer.
// Stores one pixel per load into the current lane (lane 0 = bits [0:7]) and
// advances the lane index; the index parks on the last lane until rewound so
// the packed word stays stable while the memory write is pending.
module pixel_packer
   import pixel_pkg::*;
#(
   parameter int unsigned PACK = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    load,
   input  logic                    rewind,
   input  logic [0:PIX_W-1]        pix,
   output logic                    last,
   output logic [0:PIX_W*PACK-1]   word
);

   localparam int unsigned LANE_W = lane_width(PACK);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);

   logic [0:PIX_W*PACK-1] word_q;
   logic [LANE_W-1:0]     lane_q;

   // Lane storage and lane index; clear wipes both, rewind only resets the index.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word_q <= '0;
         lane_q <= '0;
      end else begin
         if (load) begin
            word_q[int'(lane_q) * PIX_W +: PIX_W] <= pix;
            if (lane_q != LANE_LAST) begin
               lane_q <= lane_q + LANE_W'(1);
            end
         end
         if (rewind) begin
            lane_q <= '0;
         end
      end
   end

   assign last = (lane_q == LANE_LAST);
   assign word = word_q;

endmodule

// File: rtl/pixel_frame_writer.sv
// Frame writer: sink of the pixel stream. Packs PACK pixels per memory word,
// writes words sequentially from address 0, tracks row/column of the next
// pixel and pulses frame_done after the last word of the frame is accepted.
// Optional running checksum of accepted pixels: define PIXEL_WRITER_CHECKSUM_EN.
module pixel_frame_writer
   import pixel_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 256,
   parameter int unsigned IMG_HEIGHT = 256,
   parameter int unsigned PACK       = 4,
   parameter int unsigned ADDR_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [0:PIX_W-1]        pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [0:PIX_W*PACK-1]   mem_wdata,
   output logic                    mem_we,
   input  logic                    mem_ready,
   output logic [15:0]             row,
   output logic [15:0]             col,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    drop_err,
   output logic [0:15]             checksum
);

   localparam int unsigned TOTAL_WORDS = IMG_WIDTH * IMG_HEIGHT / PACK;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
   localparam logic [15:0]       COL_LAST  = 16'(IMG_WIDTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       row_q, col_q;
   logic              drop_q;
   logic              accept;
   logic              start_frame;
   logic              word_written;
   logic              lane_last;

   // A frame only starts from IDLE; start while busy is ignored.
   assign start_frame  = (state_q == IDLE) && start;
   assign accept       = (state_q == FILL) && pix_valid;
   assign word_written = (state_q == FLUSH) && mem_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore outputs.
   always_comb begin
      state_d    = state_q;
      pix_ready  = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
            end
         end
         FILL: begin
            pix_ready = 1'b1;
            busy      = 1'b1;
            if (pix_valid && lane_last) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            if (mem_ready) begin
               state_d = (addr_q == LAST_ADDR) ? DONE : FILL;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address, position and drop tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         drop_q <= 1'b0;
      end else if (start_frame) begin
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && pix_valid) begin
            drop_q <= 1'b1;
         end
         if (accept) begin
            if (col_q == COL_LAST) begin
               col_q <= '0;
               row_q <= row_q + 16'd1;
            end else begin
               col_q <= col_q + 16'd1;
            end
         end
         if (word_written) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   pixel_packer #(
      .PACK (PACK)
   ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_frame),
      .load   (accept),
      .rewind (word_written),
      .pix    (pix_in),
      .last   (lane_last),
      .word   (mem_wdata)
   );

   assign mem_addr = addr_q;
   assign row      = row_q;
   assign col      = col_q;
   assign drop_err = drop_q;

`ifdef PIXEL_WRITER_CHECKSUM_EN
   logic [15:0] sum_q;

   // Running sum of accepted pixels, modulo 2^16.
   always_ff @(posedge clk) begin
      if (rst || start_frame) begin
         sum_q <= '0;
      end else if (accept) begin
         sum_q <= sum_q + {8'h00, pix_in};
      end
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
- Sink end of the per-pixel processing stream: accepts processed 8-bit pixels one per handshake and packs PACK pixels into one memory word.
- Writes packed words sequentially into the output frame buffer.
- Tracks row/column position and signals end of frame, so a whole processed image lands in memory with no software bookkeeping.

Parameters:
- IMG_WIDTH, 256, pixels per row; must be a multiple of PACK.
- IMG_HEIGHT, 256, rows per frame.
- PACK, 4, pixels per memory word (1, 2 or 4).
- ADDR_W, 16, word-address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT/PACK.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame at word address 0.
- pix_in  in  [0:7]  pixel byte; bit 0 = MSB.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  writer accepts pix_in this cycle.
- mem_addr  out  [ADDR_W-1:0]  word address.
- mem_wdata  out  [0:8*PACK-1]  packed word; first pixel of the group in bits [0:7].
- mem_we  out  1  write request; held until mem_ready.
- mem_ready  in  1  memory accepts the write this cycle.
- row  out  [15:0]  row of the next pixel to be accepted.
- col  out  [15:0]  column of the next pixel to be accepted.
- busy  out  1  high from the cycle after start until the cycle frame_done is asserted.
- frame_done  out  1  one-cycle pulse after the last word is written.
- drop_err  out  1  sticky; pix_valid was seen while IDLE; cleared by start.
- checksum  out  [0:15]  see Optional Feature.

Behaviour:
- Reset: all outputs 0, state IDLE, lane index 0, address 0, packing buffer cleared. Reset mid-frame abandons the frame; a partial word is discarded and no write is issued.
- States and transitions:
  - IDLE: pix_ready=0. start -> FILL, clearing address, row, col, lane and drop_err. pix_valid without start sets drop_err; that pixel is not consumed.
  - FILL: pix_ready=1. When pix_valid&&pix_ready, pix_in is stored in lane `lane` (lane 0 = bits [0:7]); lane increments and col increments. When col reaches IMG_WIDTH-1 it wraps to 0 and row increments. When the pixel lands in lane PACK-1 -> FLUSH.
  - FLUSH: pix_ready=0; mem_we=1 with mem_wdata and mem_addr stable.
    - On mem_ready: lane returns to 0 and mem_addr increments.
    - If the word just written was word IMG_WIDTH*IMG_HEIGHT/PACK-1 -> DONE, otherwise -> FILL.
    - mem_ready may be low for any number of cycles; everything holds meanwhile.
  - DONE: frame_done=1 for exactly one cycle, busy drops the same cycle, then -> IDLE. row/col hold their final wrapped values (row=IMG_HEIGHT, col=0) until the next start.
- start while busy is ignored.
- Latency:
  - Pixel completing a word in cycle N gives mem_we=1 in cycle N+1.
  - A mem_ready handshake in cycle M on the final word gives frame_done in cycle M+1.
- Throughput: PACK pixels per PACK+1 cycles when mem_ready is tied high.
- Arithmetic: address, row and col are unsigned and wrap naturally. No saturation is needed because the terminal count is detected explicitly.
- PACK=1: every accepted pixel goes straight to FLUSH.

Optional Feature:
- Macro: PIXEL_WRITER_CHECKSUM_EN.
- When defined:
  - checksum = 16-bit sum modulo 2^16 of every pixel accepted in the current frame.
  - Cleared on start and on rst.
  - Final and stable from the frame_done cycle until the next start.
- When undefined: the checksum port is still present but tied to 0, and no adder is synthesized.

Decomposition:
- Shared package pixel_pkg:
  - PIX_W=8.
  - State enum {IDLE, FILL, FLUSH, DONE}.
  - Pixel-operation select codes (brighten 00, darken 01, threshold 10, invert 11), shared with the processing stage.
- One sub-module, pixel_packer: lane register file with a lane index, load enable and clear, outputting the packed word. Counters and the FSM stay in the top.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, PACK=4 unless noted):
- Basic frame: start, then pixels 0x01..0x08 with mem_ready=1 -> writes addr0=0x01020304, addr1=0x05060708; frame_done one cycle after the second handshake; checksum=0x0024 (macro on).
- Backpressure: mem_ready low for 5 cycles during the first FLUSH -> mem_we, mem_addr and mem_wdata stable; pix_ready=0 throughout; no pixels lost; same final memory image.
- Idle drop: pix_valid=1 with pix_in=0xAA before start -> drop_err=1 and pix_ready=0; next start clears drop_err.
- Reset mid-frame: rst after 3 pixels -> no mem_we; all outputs 0; a new start with 8 pixels writes a correct frame from addr 0.
- Row/col wrap: after 4 accepted pixels -> row=1, col=0; after 8 -> row=2, col=0, busy=0.
- PACK=1, 2x1 frame, pixels 0xFF and 0x00 -> two writes, addr0=0xFF and addr1=0x00; checksum=0x00FF.
